// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle for seq_alu.
interface seq_alu_if #(
  parameter int unsigned W = 4
);
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   result;
  logic             div_by_zero;

  modport master (
    output start, a, b, op,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, a, b, op,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ADD/AND, iterative shift-add MUL and
// restoring-division MOD, each W iterations, on a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned W = 4
) (
  input logic       clk,
  input logic       rst,
  seq_alu_if.slave  bus
);
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_MOD = 2'b10,
    OP_AND = 2'b11
  } op_t;

  state_t           state_q;
  op_t              op_q;
  logic [CW-1:0]    cnt_q;
  logic [2*W-1:0]   mcand_q;
  logic [W-1:0]     mplier_q;
  logic [2*W-1:0]   acc_q;
  logic [W:0]       rem_q;
  logic [W-1:0]     dvd_q;
  logic [W-1:0]     dvs_q;
  logic [2*W-1:0]   result_q;
  logic             dbz_q;
  logic             done_q;
  logic             busy_q;

  logic [2*W-1:0]   acc_d;
  logic [W:0]       rem_shift;
  logic [W:0]       rem_d;
  logic [2*W-1:0]   a_ext;
  logic [2*W-1:0]   b_ext;
  op_t              op_in;

  assign op_in = op_t'(bus.op);
  assign a_ext = {{W{1'b0}}, bus.a};
  assign b_ext = {{W{1'b0}}, bus.b};

  // One iteration of the multiplier and of the restoring divider.
  always_comb begin
    acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    rem_shift = {rem_q[W-1:0], dvd_q[W-1]};
    rem_d     = rem_shift;
    if (rem_shift >= {1'b0, dvs_q}) begin
      rem_d = rem_shift - {1'b0, dvs_q};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q     <= op_in;
            busy_q   <= 1'b1;
            mcand_q  <= a_ext;
            mplier_q <= bus.b;
            acc_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= bus.a;
            dvs_q    <= bus.b;
            cnt_q    <= CW'(W);
            if (op_in == OP_MUL || (op_in == OP_MOD && bus.b != '0)) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              dbz_q   <= (op_in == OP_MOD);
              unique case (op_in)
                OP_ADD:  result_q <= a_ext + b_ext;
                OP_AND:  result_q <= a_ext & b_ext;
                default: result_q <= a_ext;
              endcase
            end
          end
        end
        S_RUN: begin
          if (op_q == OP_MUL) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_q << 1;
          end
          cnt_q <= cnt_q - CW'(1);
          // The final iteration's result is taken straight from the step
          // logic so it lands on the same edge that enters DONE.
          if (cnt_q == CW'(1)) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            dbz_q    <= 1'b0;
            result_q <= (op_q == OP_MUL) ? acc_d : {{(W-1){1'b0}}, rem_d};
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at W=4 and W=8 against an arithmetic model.
module tb_seq_alu;
  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  seq_alu_if #(.W(4)) if4 ();
  seq_alu_if #(.W(8)) if8 ();

  seq_alu #(.W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  seq_alu #(.W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on the operands.
  function automatic longint unsigned model(input logic [1:0] op, input longint unsigned a,
                                            input longint unsigned b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a * b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return a & b;
    endcase
  endfunction

  task automatic drive(input int unsigned w, input logic s, input logic [1:0] op,
                       input int unsigned a, input int unsigned b);
    if (w == 4) begin
      if4.start = s; if4.op = op; if4.a = a[3:0]; if4.b = b[3:0];
    end else begin
      if8.start = s; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
    end
  endtask

  task automatic sample(input int unsigned w, output logic d, output logic bs,
                        output logic z, output logic [15:0] r);
    if (w == 4) begin
      d = if4.done; bs = if4.busy; z = if4.div_by_zero; r = {8'h00, if4.result};
    end else begin
      d = if8.done; bs = if8.busy; z = if8.div_by_zero; r = if8.result;
    end
  endtask

  task automatic do_op(input int unsigned w, input logic [1:0] op, input int unsigned a,
                       input int unsigned b, input string tag);
    int unsigned lat;
    int unsigned exp_lat;
    logic d, bs, z;
    logic [15:0] r;
    longint unsigned er;
    er = model(op, longint'(a), longint'(b));
    exp_lat = (op == 2'b01 || (op == 2'b10 && b != 0)) ? w + 1 : 1;
    drive(w, 1'b1, op, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, ~op, ~a, ~b);
    lat = 1;
    sample(w, d, bs, z, r);
    check({tag, "_busy1"}, 64'(bs), 64'd1);
    while (!d && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      sample(w, d, bs, z, r);
    end
    check({tag, "_done"}, 64'(d), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(r), er);
    check({tag, "_dbz"}, 64'(z), 64'((op == 2'b10 && b == 0) ? 1 : 0));
    @(posedge clk);
    @(negedge clk);
    sample(w, d, bs, z, r);
    check({tag, "_pulse"}, 64'(d), 64'd0);
    check({tag, "_idle"}, 64'(bs), 64'd0);
    check({tag, "_hold"}, 64'(r), er);
  endtask

  initial begin
    int unsigned dcount;
    logic [1:0] rop;
    int unsigned ra, rb;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(4, 1'b0, 2'b00, 0, 0);
    drive(8, 1'b0, 2'b00, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(if4.busy), 64'd0);
    check("rst_done", 64'(if4.done), 64'd0);
    check("rst_res", 64'(if4.result), 64'd0);
    check("rst_dbz", 64'(if4.div_by_zero), 64'd0);
    check("rst_res8", 64'(if8.result), 64'd0);

    do_op(4, 2'b00, 15, 15, "add_15_15");
    do_op(4, 2'b11, 12, 10, "and_12_10");
    do_op(4, 2'b01, 14, 10, "mul_14_10");
    do_op(4, 2'b01, 15, 15, "mul_15_15");
    do_op(4, 2'b01, 1, 0, "mul_1_0");
    do_op(4, 2'b10, 12, 3, "mod_12_3");
    do_op(4, 2'b10, 3, 2, "mod_3_2");
    do_op(4, 2'b10, 15, 4, "mod_15_4");
    do_op(4, 2'b10, 9, 0, "mod_9_0");
    do_op(8, 2'b01, 255, 255, "mul8_255");
    do_op(8, 2'b10, 200, 7, "mod8_200_7");

    // Start pulse and operand changes mid-MUL must be ignored.
    drive(4, 1'b1, 2'b01, 14, 10);
    @(posedge clk); @(negedge clk);
    drive(4, 1'b0, 2'b01, 14, 10);
    @(posedge clk); @(negedge clk);
    drive(4, 1'b1, 2'b00, 3, 5);
    @(posedge clk); @(negedge clk);
    drive(4, 1'b0, 2'b00, 7, 1);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (if4.done) begin
        dcount++;
        check("hs_res", 64'(if4.result), 64'd140);
      end
    end
    check("hs_dones", 64'(dcount), 64'd1);
    check("hs_hold", 64'(if4.result), 64'd140);

    // Held start on ADD is re-accepted every second cycle.
    drive(4, 1'b1, 2'b00, 6, 7);
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (if4.done) dcount++;
    end
    drive(4, 1'b0, 2'b00, 0, 0);
    check("held_dones", 64'(dcount), 64'd3);
    check("held_res", 64'(if4.result), 64'd13);

    // Reset two cycles into a MUL run aborts it and clears the result.
    drive(4, 1'b1, 2'b01, 14, 10);
    @(posedge clk); @(negedge clk);
    drive(4, 1'b0, 2'b01, 14, 10);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_res", 64'(if4.result), 64'd0);
    check("abort_busy", 64'(if4.busy), 64'd0);
    check("abort_done", 64'(if4.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (if4.done) dcount++;
    end
    check("abort_nodone", 64'(dcount), 64'd0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom_range(0, 15);
      rb = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15);
      do_op(4, rop, ra, rb, "rnd4");
    end
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom_range(0, 255);
      rb = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
      do_op(8, rop, ra, rb, "rnd8");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the team's 4-bit combinational ALU, supporting add, multiply, modulo and AND. ADD and AND complete in one cycle. MUL uses an iterative shift-add datapath and MOD uses a restoring divider, each taking W cycles. Operands are captured on a start/busy/done handshake, and the result is held until the next operation completes, so the block can sit directly on a register-mapped control path.

## Interface
- W, 4, operand width in bits (legal values 2..32); result width is 2*W
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  W  operand A (unsigned)
- b  in  W  operand B (unsigned)
- op  in  2  00 ADD, 01 MUL, 10 MOD, 11 AND
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; result valid
- result  out  2W  last completed result, registered
- div_by_zero  out  1  registered with result; set only by MOD with b==0

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1: latch a, b and op into internal registers.
  - ADD, AND, or MOD with b==0: compute the result and go to DONE.
  - MUL, or MOD with b!=0: load the counter with W and go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN: perform one iteration per cycle and decrement the counter; go to DONE when the counter reaches 0.
  - MUL step: if multiplier bit 0 is 1, add the shifted multiplicand to the accumulator. Then shift the multiplier right and the multiplicand left. Use a 2W-bit accumulator.
  - MOD step (restoring): shift the remainder left and bring in the next dividend MSB. If remainder >= b, subtract b. Use a (W+1)-bit remainder.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- result and div_by_zero update only on the edge that enters DONE. They hold their value in every other state.
- Arithmetic rules:
  - ADD: zero-extended a + b. The carry lands in bit W, and the upper bits are 0.
  - MUL: full 2W-bit product; cannot overflow.
  - MOD: a mod b, zero-extended to 2W bits.
  - AND: zero-extended a & b.
- MOD with b==0: result = zero-extended a and div_by_zero=1. All other operations set div_by_zero=0.
- start while busy=1 (RUN or DONE) is ignored; there is no queuing.
- Changes on a, b or op after capture do not affect the operation in flight.

## Timing
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, result=0, div_by_zero=0. The counter and datapath registers are cleared.
- Reset asserted mid-RUN aborts the operation. No done is produced, and result returns to 0.
- Let start be sampled at edge k:
  - ADD, AND, MOD with b==0: done=1 in cycle k+1 (latency 1). busy=1 in cycle k+1 only.
  - MUL, MOD with b!=0: RUN occupies cycles k+1 to k+W, and done=1 in cycle k+W+1 (latency W+1). busy=1 from cycle k+1 through k+W+1.
- done and the new result become visible in the same cycle.
- Minimum spacing between accepted starts:
  - 2 cycles for ADD and AND.
  - W+2 cycles for MUL and MOD.
  - A start held high continuously is accepted again in the first IDLE cycle.
- No combinational path from any input to any output.

## Test plan
- W=4, reset then idle: busy=0, done=0, result=0x00, div_by_zero=0. Asserting rst mid-MUL (2 cycles into RUN) gives result=0 immediately and no done pulse.
- W=4 ADD: a=15, b=15 gives result=0x1E with done one cycle after start. AND: a=12, b=10 gives result=0x08 with latency 1.
- W=4 MUL: a=14, b=10 gives result=0x8C (140) with done exactly 5 cycles after start. Also check a=15, b=15 gives 0xE1, and a=1, b=0 gives 0x00.
- W=4 MOD:
  - 12%3 gives 0, 3%2 gives 1, 15%4 gives 3, each with latency 5 and div_by_zero=0.
  - a=9, b=0 gives result=0x09 and div_by_zero=1 with latency 1.
- Handshake: while busy (mid-MUL), pulse start with op=00 and toggle a and b. The in-flight result must be unchanged, and no extra done pulse may follow.
- W=8 MUL: 255*255 gives result=0xFE01 with latency 9. MOD: 200%7 gives 4.
